// File: rtl/sign_extension.sv
// sign_extension: RV32I immediate generator (I/S/B/U/J), registered; optional imm_valid_o under SIGN_EXT_VALID_EN
module sign_extension #(
    parameter int INST_WIDTH = 32,
    parameter int OPCODE     = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [OPCODE-1:0]     opcode_i,
`ifdef SIGN_EXT_VALID_EN
    output logic                  imm_valid_o,
`endif
    output logic [INST_WIDTH-1:0] immediate_extended_o
);
    localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
    localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
    logic                  is_i, is_s, is_b, is_u, is_j;
    logic [INST_WIDTH-1:0] imm_c;
    // Decode the format from opcode_i and build the filled immediate; unselected fields never reach imm_c
    always_comb begin
        is_i  = (opcode_i == OP_ALUI) || (opcode_i == OP_LOAD) || (opcode_i == OP_JALR);
        is_s  = (opcode_i == OP_STORE);
        is_b  = (opcode_i == OP_BRANCH);
        is_u  = (opcode_i == OP_LUI) || (opcode_i == OP_AUIPC);
        is_j  = (opcode_i == OP_JAL);
        imm_c = is_i ? {{20{inst_i[31]}}, inst_i[31:20]} :
                is_s ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
                is_b ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
                is_u ? {inst_i[31:12], 12'h000} :
                is_j ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
                       '0;
    end
    // Register the immediate; reset wins over capture
    always_ff @(posedge clk_i) begin
        immediate_extended_o <= rst_i ? '0 : imm_c;
    end
`ifdef SIGN_EXT_VALID_EN
    // Flag recognised immediate-bearing opcodes alongside the result
    always_ff @(posedge clk_i) begin
        imm_valid_o <= rst_i ? 1'b0 : (is_i | is_s | is_b | is_u | is_j);
    end
`endif
endmodule

// File: tb/tb_sign_extension.sv
// tb_sign_extension: directed self-checking bench for sign_extension
module tb_sign_extension;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_i = 32'hFFFFFFFF;
    logic [6:0]  opcode_i = 7'b0010011;
    logic [31:0] immediate_extended_o;
`ifdef SIGN_EXT_VALID_EN
    logic        imm_valid_o;
`endif
    int checks = 0;
    int failures = 0;
    logic [31:0] prev_imm = 32'h0;
    logic        prev_v = 1'b0;

    sign_extension dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inst_i(inst_i),
        .opcode_i(opcode_i),
`ifdef SIGN_EXT_VALID_EN
        .imm_valid_o(imm_valid_o),
`endif
        .immediate_extended_o(immediate_extended_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] inst,
                        input logic [6:0] op, input logic [31:0] exp, input logic expv);
        rst_i = r;
        inst_i = inst;
        opcode_i = op;
        #1;
        chk({tag, "_hold"}, immediate_extended_o, prev_imm);
`ifdef SIGN_EXT_VALID_EN
        chk({tag, "_vhold"}, {31'h0, imm_valid_o}, {31'h0, prev_v});
`endif
        @(posedge clk_i);
        #1;
        chk(tag, immediate_extended_o, exp);
`ifdef SIGN_EXT_VALID_EN
        chk({tag, "_v"}, {31'h0, imm_valid_o}, {31'h0, expv});
`endif
        prev_imm = exp;
        prev_v = expv;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        prev_imm = 32'h0;
        prev_v = 1'b0;
        step("rst0",   1'b1, 32'hFFFFFFFF, 7'b0010011, 32'h00000000, 1'b0);
        step("rst1",   1'b1, 32'hFFFFFFFF, 7'b0010011, 32'h00000000, 1'b0);
        step("i_alui", 1'b0, 32'h80000000, 7'b0010011, 32'hFFFFF800, 1'b1);
        step("i_load", 1'b0, 32'h10100000, 7'b0000011, 32'h00000101, 1'b1);
        step("i_jalr", 1'b0, 32'h00C00167, 7'b1100111, 32'h0000000C, 1'b1);
        step("s_neg",  1'b0, 32'h80F80023, 7'b0100011, 32'hFFFFF800, 1'b1);
        step("s_zero", 1'b0, 32'h00F80023, 7'b0100011, 32'h00000000, 1'b1);
        step("u_lui",  1'b0, 32'h000170B7, 7'b0110111, 32'h00017000, 1'b1);
        step("u_auip", 1'b0, 32'h000170B7, 7'b0010111, 32'h00017000, 1'b1);
        step("b_neg",  1'b0, 32'hFE4104E3, 7'b1100011, 32'hFFFFFFE8, 1'b1);
        step("j_pos",  1'b0, 32'h0E80026F, 7'b1101111, 32'h000000E8, 1'b1);
        step("j_neg",  1'b0, 32'hF19FF26F, 7'b1101111, 32'hFFFFFF18, 1'b1);
        step("r_type", 1'b0, 32'hFFFFFFFF, 7'b0110011, 32'h00000000, 1'b0);
        step("srai",   1'b0, 32'h40005013, 7'b0010011, 32'h00000400, 1'b1);
        step("fence",  1'b0, 32'hFFFFFFFF, 7'b0001111, 32'h00000000, 1'b0);
        step("u_ones", 1'b0, 32'hFFFFFFFF, 7'b0110111, 32'hFFFFF000, 1'b1);
        step("system", 1'b0, 32'hFFFFFFFF, 7'b1110011, 32'h00000000, 1'b0);
        step("b_ones", 1'b0, 32'hFFFFFFFF, 7'b1100011, 32'hFFFFFFFE, 1'b1);
        step("rst_ovr",1'b1, 32'hFFFFFFFF, 7'b1101111, 32'h00000000, 1'b0);
        step("j_ones", 1'b0, 32'hFFFFFFFF, 7'b1101111, 32'hFFFFFFFE, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
